// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers for the byte-serial MixColumns datapath.
// The inverse multipliers are only compiled when MIXCOL_INV_EN is defined.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [7:0] byte_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

`ifdef MIXCOL_INV_EN
    function automatic byte_t gf_mul9(input byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic byte_t gf_mulb(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic byte_t gf_muld(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic byte_t gf_mule(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction
`endif

endpackage

// File: rtl/mix_column_comb.sv
// Combinational transform of one 32-bit column {a0,a1,a2,a3}, a0 in the MSB.
// Inverse coefficients exist only under MIXCOL_INV_EN; otherwise inv_i is ignored.
module mix_column_comb
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    input  logic        bypass_i,
    output logic [31:0] col_o
);

    byte_t a0, a1, a2, a3;
    logic [31:0] fwd;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign fwd = {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
                  gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

`ifdef MIXCOL_INV_EN
    logic [31:0] rev;

    assign rev = {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                  gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                  gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                  gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};

    assign col_o = bypass_i ? col_i : (inv_i ? rev : fwd);
`else
    logic unused_inv;

    assign unused_inv = inv_i;
    assign col_o      = bypass_i ? col_i : fwd;
`endif

endmodule

// File: rtl/mix_columns_stream.sv
// Byte-serial MixColumns with valid/ready on both sides and a one-column output buffer.
// Define MIXCOL_INV_EN to enable InvMixColumns selection through the inv port.
module mix_columns_stream
    import aes_pkg::*;
#(
    parameter int NUM_COLS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       inv,
    input  logic       bypass,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic [2:0][7:0] hold_q, hold_d;
    logic [1:0]      in_cnt_q, in_cnt_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic            inv_q, inv_d, byp_q, byp_d;
    logic [31:0]     buf_q, buf_d;
    logic            buf_vld_q, buf_vld_d, buf_last_q, buf_last_d;
    logic [1:0]      out_cnt_q, out_cnt_d;

    logic        xfer, state_start, col_last, load, release_c;
    logic [31:0] col_res;

    assign xfer        = in_valid && in_ready;
    assign state_start = xfer && (in_cnt_q == 2'd0) && (col_cnt_q == '0);
    assign col_last    = (col_cnt_q == CW'(NUM_COLS - 1));
    assign load        = xfer && (in_cnt_q == 2'd3);
    assign release_c   = buf_vld_q && out_ready && (out_cnt_q == 2'd3);
    // A 4th byte may only enter when the buffer is free or draining its last byte now.
    assign in_ready    = !((in_cnt_q == 2'd3) && buf_vld_q && !release_c);

    mix_column_comb u_mix (
        .col_i    ({hold_q[0], hold_q[1], hold_q[2], in_byte}),
        .inv_i    (inv_q),
        .bypass_i (byp_q),
        .col_o    (col_res)
    );

`ifndef MIXCOL_INV_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

    always_comb begin
        hold_d     = hold_q;
        in_cnt_d   = in_cnt_q;
        col_cnt_d  = col_cnt_q;
        byp_d      = byp_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        buf_last_d = buf_last_q;
        out_cnt_d  = out_cnt_q;
`ifdef MIXCOL_INV_EN
        inv_d      = state_start ? inv : inv_q;
`else
        inv_d      = 1'b0;
`endif
        if (state_start) byp_d = bypass;
        if (xfer) begin
            in_cnt_d = in_cnt_q + 2'd1;
            case (in_cnt_q)
                2'd0:    hold_d[0] = in_byte;
                2'd1:    hold_d[1] = in_byte;
                2'd2:    hold_d[2] = in_byte;
                default: col_cnt_d = col_last ? '0 : col_cnt_q + CW'(1);
            endcase
        end
        if (buf_vld_q && out_ready) out_cnt_d = out_cnt_q + 2'd1;
        if (release_c) buf_vld_d = 1'b0;
        if (load) begin
            buf_d      = col_res;
            buf_vld_d  = 1'b1;
            buf_last_d = col_last;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            in_cnt_q   <= '0;
            col_cnt_q  <= '0;
            inv_q      <= 1'b0;
            byp_q      <= 1'b0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            buf_last_q <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            hold_q     <= hold_d;
            in_cnt_q   <= in_cnt_d;
            col_cnt_q  <= col_cnt_d;
            inv_q      <= inv_d;
            byp_q      <= byp_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            buf_last_q <= buf_last_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_comb begin
        case (out_cnt_q)
            2'd0:    out_byte = buf_q[31:24];
            2'd1:    out_byte = buf_q[23:16];
            2'd2:    out_byte = buf_q[15:8];
            default: out_byte = buf_q[7:0];
        endcase
    end

    assign out_valid = buf_vld_q;
    assign out_last  = buf_vld_q && buf_last_q && (out_cnt_q == 2'd3);

endmodule

// File: tb/tb_mix_columns_stream.sv
// Directed bench: a 4-column instance is checked in full; a 1-column twin supplies per-column out_last.
module tb_mix_columns_stream;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       inv = 1'b0;
    logic       bypass = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last;
    logic [7:0] out_byte;
    logic       unused_rdy1, unused_vld1, out_last1;
    logic [7:0] unused_byte1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rand_rdy = 1'b0;

    logic [7:0] obq[$];
    bit         l4q[$];
    bit         l1q[$];
    int         ocq[$];
    int         icq[$];
    logic [9:0] expq[$];

    int         in_cnt_m = 0;
    int         out_cnt_m = 0;
    bit         occ_m = 1'b0;
    bit         stall_p = 1'b0;
    logic [9:0] stall_v = '0;

    mix_columns_stream #(.NUM_COLS(4)) dut (
        .clock(clock), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .inv(inv), .bypass(bypass), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    mix_columns_stream #(.NUM_COLS(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(unused_rdy1), .inv(inv), .bypass(bypass), .out_byte(unused_byte1),
        .out_valid(unused_vld1), .out_ready(out_ready), .out_last(out_last1)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(posedge clock);
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of handshake state; sampled on the falling edge before each rising edge.
    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            in_cnt_m  = 0;
            out_cnt_m = 0;
            occ_m     = 1'b0;
            stall_p   = 1'b0;
        end else begin
            if (stall_p) check("hold_stalled", {out_byte, out_valid, out_last}, stall_v);
            check("in_ready", in_ready, !(in_cnt_m == 3 && occ_m && !(out_cnt_m == 3 && out_ready)));
            check("out_valid", out_valid, occ_m);
            stall_p = out_valid && !out_ready;
            stall_v = {out_byte, out_valid, out_last};
            if (out_valid && out_ready) begin
                obq.push_back(out_byte);
                l4q.push_back(out_last);
                l1q.push_back(out_last1);
                ocq.push_back(cyc);
                if (out_cnt_m == 3) occ_m = 1'b0;
                out_cnt_m = (out_cnt_m + 1) % 4;
            end
            if (in_valid && in_ready) begin
                icq.push_back(cyc);
                if (in_cnt_m == 3) occ_m = 1'b1;
                in_cnt_m = (in_cnt_m + 1) % 4;
            end
        end
    end

    task automatic put(input logic [7:0] b, input logic iv, input logic bp);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        inv      = iv;
        bypass   = bp;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("put_wait", n < 200, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        inv      = 1'b0;
        bypass   = 1'b0;
    endtask

    // Mode inputs are driven with their given value only on byte 0 of a state; other bytes get the opposite.
    task automatic send_col(input logic [31:0] c, input logic iv0, input logic bp0, input bit first);
        for (int k = 0; k < 4; k++) begin
            if (first && k == 0) put(c[31-8*k -: 8], iv0, bp0);
            else                 put(c[31-8*k -: 8], !iv0, !bp0);
        end
    endtask

    task automatic exp_col(input logic [31:0] c, input bit last_state);
        for (int k = 0; k < 4; k++)
            expq.push_back({c[31-8*k -: 8], last_state && k == 3, k == 3});
    endtask

    task automatic clear_q();
        obq.delete(); l4q.delete(); l1q.delete();
        ocq.delete(); icq.delete(); expq.delete();
    endtask

    task automatic drain(input string tag, input bit timing);
        int n = 0;
        while (obq.size() < expq.size() && n < 400) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_count"}, obq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obq.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {obq[i], l4q[i], l1q[i]}, expq[i]);
        if (timing) begin
            check({tag, "_latency"}, ocq[0] - icq[3], 1);
            check({tag, "_out_rate"}, ocq[15] - ocq[0], 15);
            check({tag, "_in_rate"}, icq[15] - icq[0], 15);
        end
        clear_q();
    endtask

    initial begin
        logic [31:0] fwd_in [4];
        logic [31:0] fwd_out[4];
        logic [7:0]  b0;
        fwd_in  = '{32'hdb135345, 32'hd4bf5d30, 32'hf20a225c, 32'hc6c6c6c6};
        fwd_out = '{32'h8e4da1bc, 32'h046681e5, 32'h9fdc589d, 32'hc6c6c6c6};

        repeat (3) @(posedge clock);
        #1;
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_last1", out_last1, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 4; i++) send_col(fwd_in[i], 1'b0, 1'b0, i == 0);
        idle();
        for (int i = 0; i < 4; i++) exp_col(fwd_out[i], i == 3);
        drain("fwd", 1'b1);

`ifdef MIXCOL_INV_EN
        for (int i = 0; i < 4; i++) send_col(32'h8e4da1bc, 1'b1, 1'b0, i == 0);
        idle();
        for (int i = 0; i < 4; i++) exp_col(32'hdb135345, i == 3);
`else
        for (int i = 0; i < 4; i++) send_col(32'hd4bf5d30, 1'b1, 1'b0, i == 0);
        idle();
        for (int i = 0; i < 4; i++) exp_col(32'h046681e5, i == 3);
`endif
        drain("inv", 1'b0);

        for (int i = 0; i < 4; i++) begin
            b0 = 8'(4 * i);
            send_col({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, 1'b0, 1'b1, i == 0);
            exp_col({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, i == 3);
        end
        idle();
        drain("byp", 1'b1);

        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_col(fwd_in[i % 4], 1'b0, 1'b0, (i % 4) == 0);
            exp_col(fwd_out[i % 4], (i % 4) == 3);
        end
        idle();
        drain("stream", 1'b0);
        rand_rdy = 1'b0;

        send_col(32'hdb135345, 1'b0, 1'b0, 1'b1);
        put(8'hd4, 1'b0, 1'b0);
        put(8'hbf, 1'b0, 1'b0);
        idle();
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_byte", out_byte, 8'h00);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_last", out_last, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        clear_q();
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) send_col(fwd_in[i], 1'b0, 1'b0, i == 0);
        idle();
        for (int i = 0; i < 4; i++) exp_col(fwd_out[i], i == 3);
        drain("post_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
